btn_event_queue: RTL and testbench

//   Sits directly downstream of the per-button debouncers. Takes their one-cycle
//   "clean" press pulses and classifies each press as a single or double press
//   (same button pressed again within a time window).

---
 rtl/btn_event_queue.sv | 165 ++++++++++++++++
 tb/tb_btn_event_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_queue.sv
// Classifies debounced press pulses as single/double and queues them (show-ahead FIFO).
// Event appears one cycle after its push; consumer stalls never stall the FSM, full FIFO drops newest.
module btn_event_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         empty,
  output logic         full,
  output logic [W-1:0] head_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [W-1:0]  hold_q;
  logic          wr_en, rd_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd_en = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = push && (!full || rd_en);
  assign head_dat = empty ? hold_q : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      hold_q <= head_dat;
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !rd_en)      count <= count + CW'(1);
      else if (!wr_en && rd_en) count <= count - CW'(1);
    end
  end
endmodule

module btn_event_queue #(
  parameter int NUM_BTN    = 5,
  parameter int CODE_W     = 3,
  parameter int DBL_WINDOW = 25_000_000,
  parameter int CNT_W      = 25,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] press,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [CODE_W-1:0]  evt_code,
  output logic               evt_double,
  output logic               ovf,
  input  logic               ovf_clr
);
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              dbl;
  } evt_t;

  typedef enum logic {IDLE, ARMED} state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CODE_W-1:0] sel_idx;
  logic              press_any;
  logic              push, pop, empty, full, drop;
  evt_t              push_evt, head_evt;

  assign press_any = |press;

  // Descending scan so the lowest set bit is the final winner.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (press[i]) sel_idx = CODE_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    wcnt_d   = wcnt_q;
    push     = 1'b0;
    push_evt = '{code: pend_q, dbl: 1'b0};
    case (state_q)
      IDLE: begin
        if (press_any) begin
          pend_d  = sel_idx;
          wcnt_d  = '0;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (press_any) begin
          push = 1'b1;
          if (sel_idx == pend_q) begin
            push_evt.dbl = 1'b1;
            state_d      = IDLE;
          end else begin
            pend_d = sel_idx;
            wcnt_d = '0;
          end
        end else if (wcnt_q == CNT_W'(DBL_WINDOW - 1)) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign pop  = evt_valid && evt_ready;
  assign drop = push && full && !pop;

  btn_event_fifo #(.W(CODE_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_evt),
    .pop      (pop),
    .empty    (empty),
    .full     (full),
    .head_dat (head_evt)
  );

  assign evt_valid  = !empty;
  assign evt_code   = head_evt.code;
  assign evt_double = head_evt.dbl;

  // Set wins over clear when a drop coincides with ovf_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end
endmodule

// File: tb/tb_btn_event_queue.sv
// Bench for btn_event_queue: latency table, overflow/reset sequences, random run against a queue model.
module tb_btn_event_queue;
  localparam int NB  = 5;
  localparam int WIN = 8;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NB-1:0] press = '0;
  logic          evt_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          evt_valid, evt_double, ovf;
  logic [2:0]    evt_code;

  btn_event_queue #(.NUM_BTN(NB), .CODE_W(3), .DBL_WINDOW(WIN), .CNT_W(4), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .press(press), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_double(evt_double), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct { int code; int dbl; } evt_t;
  typedef struct { int cyc; int code; int dbl; } obs_t;
  evt_t m_q[$];
  obs_t ev_q[$];
  bit   m_pv;
  int   m_pc, m_arm, m_ovf, m_last_code, m_last_dbl;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pv = 0; m_pc = 0; m_arm = 0; m_ovf = 0; m_last_code = 0; m_last_dbl = 0;
  endtask

  // One clock cycle: apply inputs, compare against model mid-cycle, advance model.
  task automatic step(input logic [NB-1:0] p, input bit r, input bit c);
    bit   pop, push, drop, full;
    int   idx;
    evt_t e;
    press = p; evt_ready = r; ovf_clr = c;
    @(negedge clk);
    if (m_q.size() > 0) begin
      m_last_code = m_q[0].code;
      m_last_dbl  = m_q[0].dbl;
    end
    chk("evt_valid", int'(evt_valid), int'(m_q.size() > 0));
    chk("evt_code", int'(evt_code), m_last_code);
    chk("evt_double", int'(evt_double), m_last_dbl);
    chk("ovf", int'(ovf), m_ovf);
    if (evt_valid) ev_q.push_back('{cyc, int'(evt_code), int'(evt_double)});
    pop = (m_q.size() > 0) && r;
    push = 0;
    idx = -1;
    for (int i = NB - 1; i >= 0; i--) if (p[i]) idx = i;
    if (idx >= 0) begin
      if (m_pv && idx == m_pc) begin
        push = 1; e = '{m_pc, 1}; m_pv = 0;
      end else if (m_pv) begin
        push = 1; e = '{m_pc, 0}; m_pc = idx; m_arm = cyc;
      end else begin
        m_pv = 1; m_pc = idx; m_arm = cyc;
      end
    end else if (m_pv && (cyc - m_arm) == WIN) begin
      push = 1; e = '{m_pc, 0}; m_pv = 0;
    end
    full = (m_q.size() == DEP);
    drop = push && full && !pop;
    if (pop) void'(m_q.pop_front());
    if (push && !drop) m_q.push_back(e);
    if (drop) m_ovf = 1;
    else if (c) m_ovf = 0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    string         name;
    logic [NB-1:0] p0;
    int            d;
    logic [NB-1:0] p1;
    int            n;
    int            c0, b0, l0;
    int            c1, b1, l1;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int t;
    for (int k = 0; k < 20; k++) step('0, 1'b1, 1'b0);
    ev_q.delete();
    t = cyc;
    step(v.p0, 1'b1, 1'b0);
    for (int k = 1; k <= 30; k++) step((v.p1 != '0 && k == v.d) ? v.p1 : '0, 1'b1, 1'b0);
    chk({v.name, "_count"}, ev_q.size(), v.n);
    if (v.n >= 1 && ev_q.size() >= 1) begin
      chk({v.name, "_code0"}, ev_q[0].code, v.c0);
      chk({v.name, "_dbl0"}, ev_q[0].dbl, v.b0);
      chk({v.name, "_lat0"}, ev_q[0].cyc - t, v.l0);
    end
    if (v.n >= 2 && ev_q.size() >= 2) begin
      chk({v.name, "_code1"}, ev_q[1].code, v.c1);
      chk({v.name, "_dbl1"}, ev_q[1].dbl, v.b1);
      chk({v.name, "_lat1"}, ev_q[1].cyc - t, v.l1);
    end
  endtask

  initial begin
    logic [NB-1:0] lastp;
    logic [NB-1:0] rp;
    vecs[0] = '{"t1_single",     5'b00100, 0, 5'b00000, 1, 2, 0, 9, 0, 0, 0};
    vecs[1] = '{"t2_double",     5'b00010, 5, 5'b00010, 1, 1, 1, 6, 0, 0, 0};
    vecs[2] = '{"t3_rearm",      5'b00001, 3, 5'b01000, 2, 0, 0, 4, 3, 0, 12};
    vecs[3] = '{"t5_multi",      5'b01010, 3, 5'b00010, 1, 1, 1, 4, 0, 0, 0};
    vecs[4] = '{"edge_dbl",      5'b00100, 8, 5'b00100, 1, 2, 1, 9, 0, 0, 0};
    vecs[5] = '{"after_window",  5'b00100, 9, 5'b00100, 2, 2, 0, 9, 2, 0, 18};
    vecs[6] = '{"edge_rearm",    5'b00001, 8, 5'b10000, 2, 0, 0, 9, 4, 0, 17};

    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_code", int'(evt_code), 0);
    chk("rst_double", int'(evt_double), 0);
    chk("rst_ovf", int'(ovf), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // T4: stalled consumer, five doubles into a four-entry FIFO.
    for (int k = 0; k < 20; k++) step('0, 1'b1, 1'b0);
    for (int b = 0; b < 5; b++) begin
      step(NB'(1 << b), 1'b0, 1'b0);
      step(NB'(1 << b), 1'b0, 1'b0);
    end
    step('0, 1'b0, 1'b0);
    chk("t4_ovf_set", int'(ovf), 1);
    for (int k = 0; k < 4; k++) begin
      chk("t4_drain_valid", int'(evt_valid), 1);
      chk("t4_drain_code", int'(evt_code), k);
      chk("t4_drain_dbl", int'(evt_double), 1);
      step('0, 1'b1, 1'b0);
    end
    chk("t4_empty", int'(evt_valid), 0);
    chk("t4_ovf_held", int'(ovf), 1);
    step('0, 1'b1, 1'b1);
    chk("t4_ovf_clr", int'(ovf), 0);

    // T6: asynchronous reset with an event queued and a press pending.
    step(5'b00001, 1'b0, 1'b0);
    step(5'b00001, 1'b0, 1'b0);
    step(5'b10000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step('0, 1'b0, 1'b0);
    chk("t6_pre_valid", int'(evt_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(evt_valid), 0);
    chk("t6_async_ovf", int'(ovf), 0);
    model_reset();
    press = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ev_q.delete();
    for (int k = 0; k < 12; k++) step('0, 1'b1, 1'b0);
    chk("t6_no_event", ev_q.size(), 0);
    run_vec(vecs[0]);

    // Random traffic against the model, including stalls and overflow.
    lastp = 5'b00001;
    for (int k = 0; k < 3000; k++) begin
      rp = '0;
      case ($urandom_range(0, 7))
        0: rp = NB'($urandom_range(1, 31));
        1: rp = lastp;
        2: rp = NB'(1 << $urandom_range(0, NB - 1));
        default: rp = '0;
      endcase
      if (rp != '0) lastp = rp;
      step(rp, ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, want finish before 2000000");
    $fatal(1, "timeout");
  end
endmodule
